// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the PC, registers memory words into a one-entry IR,
// and handles stall, branch redirect/flush and terminal HALT. Optional counter: FETCH_PERF_EN.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] PC_STEP   = 16'd2,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clk_pi,
  input  logic        reset_pi,
  output logic [15:0] pc_po,
  input  logic [15:0] instr_pi,
  input  logic        stall_pi,
  input  logic        branch_pi,
  input  logic [15:0] branch_target_pi,
  output logic        ins_valid_po,
  output logic [15:0] ins_po,
  output logic [15:0] ins_pc_po,
  output logic        halted_po,
  output logic [15:0] fetch_count_po,
  output logic [1:0]  state_po
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTING = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  state_t      state;
  logic        accept;
  logic [15:0] redirect_pc;

  // IR handshake: ins_valid_po is the valid and !stall_pi the ready; the IR is
  // consumed on any rising edge where both are high, and valid never drops without that
  // handshake except on a branch flush or reset.
  assign accept      = ins_valid_po && !stall_pi;
  assign redirect_pc = {branch_target_pi[15:1], 1'b0};
  assign state_po    = state;

  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      state        <= ST_RUN;
      pc_po        <= RESET_PC;
      ins_valid_po <= 1'b0;
      ins_po       <= 16'h0000;
      ins_pc_po    <= 16'h0000;
      halted_po    <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (branch_pi) begin
            // The word on instr_pi belongs to the wrong path, even a HALT encoding.
            pc_po        <= redirect_pc;
            ins_valid_po <= 1'b0;
          end else if (!stall_pi) begin
            ins_po       <= instr_pi;
            ins_pc_po    <= pc_po;
            ins_valid_po <= 1'b1;
            if (instr_pi == HALT_WORD) begin
              state <= ST_HALTING;
            end else begin
              pc_po <= pc_po + PC_STEP;
            end
          end
        end
        ST_HALTING: begin
          if (branch_pi) begin
            pc_po        <= redirect_pc;
            ins_valid_po <= 1'b0;
            state        <= ST_RUN;
          end else if (accept) begin
            ins_valid_po <= 1'b0;
            halted_po    <= 1'b1;
            state        <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          ins_valid_po <= 1'b0;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      fetch_count_po <= 16'h0000;
    end else if (accept && (fetch_count_po != 16'hFFFF)) begin
      fetch_count_po <= fetch_count_po + 16'd1;
    end
  end
`else
  assign fetch_count_po = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: small instruction image, stall, branch, wrap,
// HALT and asynchronous reset scenarios checked with immediate assertions.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc;
  logic [15:0] instr;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [15:0] target = 16'h0000;
  logic        ins_valid;
  logic [15:0] ins;
  logic [15:0] ins_pc;
  logic        halted;
  logic [15:0] fetch_count;
  logic [1:0]  state;

  logic [15:0] mem [32];
  int n_checks = 0;
  int n_fails  = 0;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  fetch_unit dut (
    .clk_pi(clk), .reset_pi(reset), .pc_po(pc), .instr_pi(instr),
    .stall_pi(stall), .branch_pi(branch), .branch_target_pi(target),
    .ins_valid_po(ins_valid), .ins_po(ins), .ins_pc_po(ins_pc),
    .halted_po(halted), .fetch_count_po(fetch_count), .state_po(state)
  );

  // clock / memory model
  always #5 clk = ~clk;
  always_comb instr = (pc == 16'hFFFE) ? 16'h1234 : mem[pc[5:1]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cnt(input logic [15:0] v);
    return PERF ? v : 16'h0000;
  endfunction

  task automatic chk_ir(input string tag, input logic v, input logic [15:0] w,
                        input logic [15:0] wpc, input logic [15:0] p);
    chk({tag, ".valid"}, {15'd0, ins_valid}, {15'd0, v});
    chk({tag, ".ins"}, ins, w);
    chk({tag, ".ins_pc"}, ins_pc, wpc);
    chk({tag, ".pc"}, pc, p);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0]  = 16'h3004;
    mem[1]  = 16'h3200;
    mem[15] = 16'hFFFF;

    // reset values before any clock edge
    #2;
    chk_ir("reset", 1'b0, 16'h0000, 16'h0000, 16'h0000);
    chk("reset.halted", {15'd0, halted}, 16'd0);
    chk("reset.count", fetch_count, 16'h0000);
    chk("reset.state", {14'd0, state}, 16'd0);
    #1 reset = 1'b0;

    // sequential fetch
    tick();
    chk_ir("e1", 1'b1, 16'h3004, 16'h0000, 16'h0002);
    tick();
    chk_ir("e2", 1'b1, 16'h3200, 16'h0002, 16'h0004);
    tick();
    chk_ir("e3", 1'b1, 16'h1002, 16'h0004, 16'h0006);
    chk("e3.count", fetch_count, cnt(16'd2));

    // stall three edges
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ir("stall", 1'b1, 16'h1002, 16'h0004, 16'h0006);
    end
    stall = 1'b0;
    tick();
    chk_ir("unstall", 1'b1, 16'h1003, 16'h0006, 16'h0008);
    chk("unstall.count", fetch_count, cnt(16'd3));

    // branch with stall: branch wins, bit 0 cleared
    branch = 1'b1; target = 16'h0007; stall = 1'b1;
    tick();
    chk("br.pc", pc, 16'h0006);
    chk("br.valid", {15'd0, ins_valid}, 16'd0);
    branch = 1'b0; stall = 1'b0;
    tick();
    chk_ir("br.next", 1'b1, 16'h1003, 16'h0006, 16'h0008);
    chk("br.count", fetch_count, cnt(16'd3));

    // wrap at top of address space
    branch = 1'b1; target = 16'hFFFE;
    tick();
    chk("wrap.pc0", pc, 16'hFFFE);
    branch = 1'b0;
    tick();
    chk_ir("wrap", 1'b1, 16'h1234, 16'hFFFE, 16'h0000);
    chk("wrap.count", fetch_count, cnt(16'd4));

    // HALT at pc 30 with two stalled edges
    branch = 1'b1; target = 16'h001E;
    tick();
    chk("halt.pc0", pc, 16'h001E);
    branch = 1'b0;
    tick();
    chk_ir("halting", 1'b1, 16'hFFFF, 16'h001E, 16'h001E);
    chk("halting.state", {14'd0, state}, 16'd1);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_ir("halt.stall", 1'b1, 16'hFFFF, 16'h001E, 16'h001E);
      chk("halt.stall.halted", {15'd0, halted}, 16'd0);
    end
    stall = 1'b0;
    tick();
    chk_ir("halted", 1'b0, 16'hFFFF, 16'h001E, 16'h001E);
    chk("halted.flag", {15'd0, halted}, 16'd1);
    chk("halted.count", fetch_count, cnt(16'd6));
    branch = 1'b1; target = 16'h0000;
    tick();
    tick();
    chk_ir("halted.br", 1'b0, 16'hFFFF, 16'h001E, 16'h001E);
    chk("halted.br.flag", {15'd0, halted}, 16'd1);
    chk("halted.br.state", {14'd0, state}, 16'd2);
    chk("halted.br.count", fetch_count, cnt(16'd6));
    branch = 1'b0;

    // reset out of HALTED, mid-cycle
    #2 reset = 1'b1;
    #1;
    chk_ir("rst.halted", 1'b0, 16'h0000, 16'h0000, 16'h0000);
    chk("rst.halted.flag", {15'd0, halted}, 16'd0);
    chk("rst.halted.count", fetch_count, 16'h0000);
    reset = 1'b0;
    tick();
    chk_ir("restart", 1'b1, 16'h3004, 16'h0000, 16'h0002);

    // branch while HALTING returns to RUN
    branch = 1'b1; target = 16'h001E;
    tick();
    branch = 1'b0;
    tick();
    chk("hb.state0", {14'd0, state}, 16'd1);
    branch = 1'b1; target = 16'h0004; stall = 1'b1;
    tick();
    chk("hb.state", {14'd0, state}, 16'd0);
    chk("hb.pc", pc, 16'h0004);
    chk("hb.valid", {15'd0, ins_valid}, 16'd0);
    branch = 1'b0; stall = 1'b0;
    tick();
    chk_ir("hb.next", 1'b1, 16'h1002, 16'h0004, 16'h0006);
    chk("hb.halted", {15'd0, halted}, 16'd0);

    // reset asserted between edges during a stall
    stall = 1'b1;
    tick();
    #2 reset = 1'b1;
    #1;
    chk_ir("rst.stall", 1'b0, 16'h0000, 16'h0000, 16'h0000);
    chk("rst.stall.count", fetch_count, 16'h0000);
    stall = 1'b0;
    reset = 1'b0;
    tick();
    chk_ir("rst.restart", 1'b1, 16'h3004, 16'h0000, 16'h0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
